// File: rtl/csr_reg_file_if.sv
// Bus between the decode/execute stage and the machine-mode CSR file:
// CSR access, MRET/trap redirect and the level interrupt inputs.
interface csr_reg_file_if;
  logic        valid;
  logic        csr_reg_wr;
  logic        csr_reg_rd;
  logic        is_mret;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] rdata;
  logic        epc_taken;
  logic [31:0] epc;

  modport master (
    output valid, csr_reg_wr, csr_reg_rd, is_mret, addr, wdata, pc,
           timer_irq, ext_irq,
    input  rdata, epc_taken, epc
  );

  modport slave (
    input  valid, csr_reg_wr, csr_reg_rd, is_mret, addr, wdata, pc,
           timer_irq, ext_irq,
    output rdata, epc_taken, epc
  );
endinterface

// File: rtl/csr_reg_file.sv
// Machine-mode CSR file with interrupt trap entry, MRET return and a
// fixed-length redirect holdoff (FLUSH) after every redirect.
module csr_reg_file #(
  parameter int FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  csr_reg_file_if.slave bus
);

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
  localparam logic [31:0] MIE_MASK     = 32'h0000_0880;
  localparam logic [31:0] MTVEC_MASK   = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK    = 32'hFFFF_FFFC;
  localparam logic [2:0]  FLUSH_LAST   = 3'(FLUSH_CYCLES - 1);

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTI_BIT  = 7;
  localparam int MEI_BIT  = 11;

  state_t      r_state;
  logic [2:0]  r_flush_cnt;
  logic [31:0] r_mstatus;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        r_mip_mtip;
  logic        r_mip_meip;

  logic        w_irq_pend;
  logic        w_ext_sel;
  logic        w_run;
  logic        w_trap;
  logic        w_mret;
  logic        w_wr_en;
  logic [4:0]  w_cause_code;
  logic [31:0] w_vec_base;
  logic [31:0] w_trap_target;
  logic [31:0] w_mip_val;
  logic [31:0] w_rdata;
  logic [31:0] w_epc;

  assign w_ext_sel  = r_mip_meip & r_mie[MEI_BIT];
  assign w_irq_pend = r_mstatus[MIE_BIT] &
                      (w_ext_sel | (r_mip_mtip & r_mie[MTI_BIT]));

  // MRET wins over a pending interrupt; the interrupt is seen again after FLUSH.
  assign w_run  = (r_state == ST_RUN);
  assign w_mret = w_run & bus.valid & bus.is_mret;
  assign w_trap = w_run & bus.valid & ~bus.is_mret & w_irq_pend;

  assign w_wr_en      = bus.csr_reg_wr & bus.valid & ~w_trap;
  assign w_cause_code = w_ext_sel ? 5'd11 : 5'd7;
  assign w_vec_base   = {r_mtvec[31:2], 2'b00};
  assign w_trap_target = (r_mtvec[1:0] == 2'b00) ? w_vec_base
                       : w_vec_base + {25'b0, w_cause_code, 2'b00};

  assign w_mip_val = {20'b0, r_mip_meip, 3'b0, r_mip_mtip, 7'b0};

  // NOTE: every output of a combinational block gets a default before the
  // case/if so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_rdata = '0;
    if (bus.csr_reg_rd) begin
      case (bus.addr)
        ADDR_MSTATUS: w_rdata = r_mstatus;
        ADDR_MIE:     w_rdata = r_mie;
        ADDR_MTVEC:   w_rdata = r_mtvec;
        ADDR_MEPC:    w_rdata = r_mepc;
        ADDR_MCAUSE:  w_rdata = r_mcause;
        ADDR_MIP:     w_rdata = w_mip_val;
        default:      w_rdata = '0;
      endcase
    end
  end

  always_comb begin
    w_epc = '0;
    if (w_trap) begin
      w_epc = w_trap_target;
    end else if (w_mret) begin
      w_epc = r_mepc;
    end
  end

  assign bus.rdata     = w_rdata;
  assign bus.epc       = w_epc;
  assign bus.epc_taken = w_trap | w_mret;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values; later assignments in this block
  // deliberately override earlier ones (trap/MRET over a CSR write).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_mstatus   <= '0;
      r_mie       <= '0;
      r_mtvec     <= '0;
      r_mepc      <= '0;
      r_mcause    <= '0;
      r_mip_mtip  <= 1'b0;
      r_mip_meip  <= 1'b0;
    end else begin
      r_mip_mtip <= bus.timer_irq;
      r_mip_meip <= bus.ext_irq;

      if (w_wr_en) begin
        case (bus.addr)
          ADDR_MSTATUS: r_mstatus <= bus.wdata & MSTATUS_MASK;
          ADDR_MIE:     r_mie     <= bus.wdata & MIE_MASK;
          ADDR_MTVEC:   r_mtvec   <= bus.wdata & MTVEC_MASK;
          ADDR_MEPC:    r_mepc    <= bus.wdata & MEPC_MASK;
          ADDR_MCAUSE:  r_mcause  <= bus.wdata;
          default:      ;
        endcase
      end

      case (r_state)
        ST_RUN: begin
          if (w_trap) begin
            r_mepc              <= bus.pc;
            r_mcause            <= {1'b1, 26'b0, w_cause_code};
            r_mstatus[MPIE_BIT] <= r_mstatus[MIE_BIT];
            r_mstatus[MIE_BIT]  <= 1'b0;
            r_state             <= ST_FLUSH;
            r_flush_cnt         <= FLUSH_LAST;
          end else if (w_mret) begin
            r_mstatus[MIE_BIT]  <= r_mstatus[MPIE_BIT];
            r_mstatus[MPIE_BIT] <= 1'b1;
            r_state             <= ST_FLUSH;
            r_flush_cnt         <= FLUSH_LAST;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= ST_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_reg_file.sv
// Directed bench for csr_reg_file: a word-level CSR model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_csr_reg_file;

  localparam int FLUSH_CYCLES = 2;

  logic clk;
  logic rst;
  csr_reg_file_if bus ();

  csr_reg_file #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: whole CSR words plus the number of holdoff cycles left.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip;
  int          m_flush_left;
  logic [31:0] m_old_ms, m_base, m_exp_epc, m_exp_rdata;
  logic        m_pend, m_trap, m_mret;
  int          m_code;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    m_mstatus = '0; m_mie = '0; m_mtvec = '0; m_mepc = '0; m_mcause = '0;
    m_mip = '0; m_flush_left = 0;
    forever begin
      @(negedge clk);
      m_pend = m_mstatus[3] && ((m_mip[11] && m_mie[11]) || (m_mip[7] && m_mie[7]));
      m_trap = (m_flush_left == 0) && bus.valid && !bus.is_mret && m_pend;
      m_mret = (m_flush_left == 0) && bus.valid && bus.is_mret;
      m_code = (m_mip[11] && m_mie[11]) ? 11 : 7;
      m_base = {m_mtvec[31:2], 2'b00};
      m_exp_epc = 32'h0;
      if (m_trap) m_exp_epc = (m_mtvec[1:0] == 2'b00) ? m_base : m_base + 32'(4 * m_code);
      else if (m_mret) m_exp_epc = m_mepc;
      m_exp_rdata = bus.csr_reg_rd ? m_read(bus.addr) : 32'h0;

      if (cmp_en) begin
        check("cmp_epc_taken", {31'b0, bus.epc_taken}, {31'b0, (m_trap || m_mret)});
        check("cmp_epc", bus.epc, m_exp_epc);
        check("cmp_rdata", bus.rdata, m_exp_rdata);
      end

      if (rst) begin
        m_mstatus = '0; m_mie = '0; m_mtvec = '0; m_mepc = '0; m_mcause = '0;
        m_mip = '0; m_flush_left = 0;
      end else begin
        m_old_ms = m_mstatus;
        if (m_flush_left > 0) m_flush_left--;
        if (bus.csr_reg_wr && bus.valid && !m_trap) begin
          case (bus.addr)
            12'h300: m_mstatus = bus.wdata & 32'h88;
            12'h304: m_mie     = bus.wdata & 32'h880;
            12'h305: m_mtvec   = bus.wdata & ~32'h2;
            12'h341: m_mepc    = bus.wdata & ~32'h3;
            12'h342: m_mcause  = bus.wdata;
            default: ;
          endcase
        end
        if (m_trap) begin
          m_mepc       = bus.pc;
          m_mcause     = 32'h8000_0000 | 32'(m_code);
          m_mstatus    = m_old_ms[3] ? 32'h80 : 32'h0;
          m_flush_left = FLUSH_CYCLES;
        end
        if (m_mret) begin
          m_mstatus    = 32'h80 | (m_old_ms[7] ? 32'h8 : 32'h0);
          m_flush_left = FLUSH_CYCLES;
        end
        m_mip = (bus.ext_irq ? 32'h800 : 32'h0) | (bus.timer_irq ? 32'h80 : 32'h0);
      end
    end
  end

  task automatic cyc(input logic v, input logic wr, input logic rd, input logic mr,
                     input logic [11:0] a, input logic [31:0] wd, input logic [31:0] p);
    @(posedge clk);
    #1;
    bus.valid      = v;
    bus.csr_reg_wr = wr;
    bus.csr_reg_rd = rd;
    bus.is_mret    = mr;
    bus.addr       = a;
    bus.wdata      = wd;
    bus.pc         = p;
    #1;
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, a, d, 32'h0);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, a, 32'h0, 32'h0);
    check(name, bus.rdata, exp);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0);
  endtask

  logic [11:0] reset_addrs [7] = '{12'h300, 12'h304, 12'h305, 12'h341,
                                   12'h342, 12'h344, 12'h7C0};

  initial begin
    rst = 1'b1;
    bus.valid = 1'b0; bus.csr_reg_wr = 1'b0; bus.csr_reg_rd = 1'b0;
    bus.is_mret = 1'b0; bus.addr = '0; bus.wdata = '0; bus.pc = '0;
    bus.timer_irq = 1'b0; bus.ext_irq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    rst    = 1'b0;
    #1;
    check("reset_epc_taken", {31'b0, bus.epc_taken}, 32'h0);
    check("reset_epc", bus.epc, 32'h0);
    for (int i = 0; i < 7; i++) rd_chk("reset_rdata", reset_addrs[i], 32'h0);

    // Basic access, legalisation, read-only mip, pre-write read value.
    wr_csr(12'h300, 32'h8);
    rd_chk("mstatus_rd", 12'h300, 32'h8);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'h300, 32'h0, 32'h0);
    check("rd_low_zero", bus.rdata, 32'h0);
    wr_csr(12'h344, 32'hFFFF_FFFF);
    rd_chk("mip_readonly", 12'h344, 32'h0);
    wr_csr(12'h304, 32'hFFFF_FFFF);
    rd_chk("mie_legal", 12'h304, 32'h880);
    wr_csr(12'h341, 32'h47);
    rd_chk("mepc_legal", 12'h341, 32'h44);
    wr_csr(12'h305, 32'h103);
    rd_chk("mtvec_legal", 12'h305, 32'h101);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 12'h342, 32'h5, 32'h0);
    check("rd_prewrite", bus.rdata, 32'h0);
    rd_chk("mcause_rd", 12'h342, 32'h5);
    wr_csr(12'h123, 32'hABCD);
    rd_chk("unmapped_rd", 12'h123, 32'h0);

    // Direct-mode timer trap.
    wr_csr(12'h304, 32'h80);
    wr_csr(12'h305, 32'h100);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h40);
    bus.timer_irq = 1'b1;
    check("trap_latency", {31'b0, bus.epc_taken}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h40);
    check("trap_taken", {31'b0, bus.epc_taken}, 32'h1);
    check("trap_epc", bus.epc, 32'h100);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h44);
    check("flush1_quiet", {31'b0, bus.epc_taken}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h48);
    check("flush2_quiet", {31'b0, bus.epc_taken}, 32'h0);
    bus.timer_irq = 1'b0;
    rd_chk("trap_mepc", 12'h341, 32'h40);
    rd_chk("trap_mcause", 12'h342, 32'h8000_0007);
    rd_chk("trap_mstatus", 12'h300, 32'h80);

    // Vectored mode, external beats timer, coincident mepc write dropped.
    wr_csr(12'h305, 32'h201);
    wr_csr(12'h304, 32'h880);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h300, 32'h8, 32'h0);
    bus.timer_irq = 1'b1;
    bus.ext_irq   = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h341, 32'hDEAD_0000, 32'h80);
    check("vec_taken", {31'b0, bus.epc_taken}, 32'h1);
    check("vec_epc", bus.epc, 32'h22C);
    bus.ext_irq = 1'b0;
    idle();
    idle();
    rd_chk("vec_mepc_pc", 12'h341, 32'h80);
    rd_chk("vec_mcause", 12'h342, 32'h8000_000B);

    // MRET with an interrupt pending, then the trap after FLUSH.
    wr_csr(12'h341, 32'h44);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h300, 32'h88, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 12'h0, 32'h0, 32'h50);
    check("mret_taken", {31'b0, bus.epc_taken}, 32'h1);
    check("mret_epc", bus.epc, 32'h44);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h342, 32'h33, 32'h54);
    check("mret_flush1", {31'b0, bus.epc_taken}, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 12'h300, 32'h0, 32'h58);
    check("mret_flush2", {31'b0, bus.epc_taken}, 32'h0);
    check("mret_mstatus", bus.rdata, 32'h88);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h60);
    check("post_mret_taken", {31'b0, bus.epc_taken}, 32'h1);
    check("post_mret_epc", bus.epc, 32'h21C);

    // Reset during FLUSH with an interrupt pending.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h300, 32'h88, 32'h64);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h68);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h70);
    rst = 1'b0;
    #1;
    check("rst_taken", {31'b0, bus.epc_taken}, 32'h0);
    check("rst_epc", bus.epc, 32'h0);
    rd_chk("rst_mstatus", 12'h300, 32'h0);
    rd_chk("rst_mepc", 12'h341, 32'h0);
    rd_chk("rst_mcause", 12'h342, 32'h0);
    rd_chk("rst_mtvec", 12'h305, 32'h0);

    // FSM is back in RUN: a fresh trap is accepted straight away.
    wr_csr(12'h304, 32'h80);
    wr_csr(12'h300, 32'h8);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h90);
    check("rst_run_taken", {31'b0, bus.epc_taken}, 32'h1);
    check("rst_run_epc", bus.epc, 32'h0);
    bus.timer_irq = 1'b0;
    repeat (3) idle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_reg_file.md
CSR_REG_FILE -- requirements
Module: csr_reg_file

Interface
REQ-001 Parameter: FLUSH_CYCLES, 2, redirect holdoff length in cycles (range 1..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 valid  input  1  the instruction at this stage is live (not a bubble or squashed).
REQ-005 csr_reg_wr  input  1  CSR write request from the decoder.
REQ-006 csr_reg_rd  input  1  CSR read request from the decoder.
REQ-007 is_mret  input  1  current instruction is MRET.
REQ-008 addr  input  12  CSR address (inst[31:20]).
REQ-009 wdata  input  32  CSR write data.
REQ-010 pc  input  32  PC of the current instruction.
REQ-011 timer_irq  input  1  level timer interrupt.
REQ-012 ext_irq  input  1  level external interrupt.
REQ-013 rdata  output  32  CSR read data.
REQ-014 epc_taken  output  1  PC redirect request.
REQ-015 epc  output  32  redirect target.

Function
REQ-016 CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7; other bits read 0); mie 0x304 (MTIE bit 7, MEIE bit 11); mtvec 0x305 (base [31:2], mode [1:0]); mepc 0x341; mcause 0x342; mip 0x344.
REQ-017 mip is read-only: MTIP bit 7 <= timer_irq and MEIP bit 11 <= ext_irq every cycle (1-cycle registered latency).
REQ-018 rdata is combinational: the value of the addressed CSR when csr_reg_rd=1, else 0; unmapped addresses read 0; it returns the pre-write value in a cycle that also writes.
REQ-019 A write commits at the clock edge when csr_reg_wr & valid & no trap is taken that cycle; writes to unmapped addresses and to mip are ignored.
REQ-020 Write legalisation: mepc[1:0] is forced to 00, mtvec[1] is forced to 0, and unimplemented mstatus/mie bits stay 0.
REQ-021 irq_pend = mstatus.MIE & ((mip.MEIP & mie.MEIE) | (mip.MTIP & mie.MTIE)).
REQ-022 FSM states: RUN, FLUSH.
REQ-023 In RUN, a trap is taken when irq_pend & valid & !is_mret.
REQ-024 On a trap, in the same cycle: epc_taken=1, and epc = mtvec base if mode=0, else base + 4*cause_code.
REQ-025 On a trap, at the clock edge:
- mepc <= pc;
- mcause <= {1'b1, 27'b0, code}, where code=11 (external) has priority over code=7 (timer);
- MPIE <= MIE and MIE <= 0;
- the FSM enters FLUSH.
REQ-026 MRET in RUN with valid=1:
- same cycle: epc_taken=1 and epc=mepc;
- at the clock edge: MIE <= MPIE, MPIE <= 1, and the FSM enters FLUSH.
REQ-027 MRET has priority over a pending interrupt in the same cycle; the interrupt is re-evaluated after FLUSH.
REQ-028 FLUSH lasts FLUSH_CYCLES cycles (counter), then returns to RUN; during FLUSH, epc_taken=0, no trap or MRET is accepted, and valid CSR writes are still accepted.
REQ-029 When epc_taken=0, epc SHALL be 0.
REQ-030 Interrupts not taken remain pending (level-sensitive) and are not lost while in FLUSH.

Reset
REQ-031 While rst=1 at a clock edge, all CSRs are set to 0, the FSM goes to RUN and the counter to 0; rst has priority over a simultaneous write, trap or MRET.
REQ-032 After reset: epc_taken=0, epc=0, rdata=0 for every address.

Verification
REQ-033 Write 0x300=0x8, read 0x300 with wdata=0 -> rdata=0x8 on the read; a write to 0x344 -> mip unchanged.
REQ-034 mstatus=0x8, mie=0x80, mtvec=0x100, timer_irq rises at cycle N with pc=0x40 and valid=1:
- at N+1: epc_taken=1, epc=0x100;
- after the edge: mepc=0x40, mcause=0x80000007, mstatus=0x80;
- no redirect for the next 2 cycles.
REQ-035 Vectored mode: mtvec=0x201, ext_irq and timer_irq asserted together -> epc=0x22C and mcause=0x8000000B.
REQ-036 mepc=0x44, MPIE=1, is_mret=1 with irq_pend=1 -> epc_taken=1, epc=0x44, MIE=1 after the edge, and no trap that cycle; the trap is taken once FLUSH ends.
REQ-037 Trap coincident with a valid csr_reg_wr to 0x341 -> the write is dropped and mepc=pc.
REQ-038 rst asserted while in FLUSH with irq pending -> all CSRs 0, RUN, epc_taken=0 in the next cycle.
